// File: rtl/sw_demux_capture.sv
// sw_demux_capture: steers a synchronised 4-bit switch value into register X or Y.
// A debounced KEY[0] press loads the value, and a KEY[1] press clears the selected register.
// After each write, LEDR[8] shows a timed acknowledge.

// Per-key debouncer. It also produces a registered one-cycle pulse on each accepted press.
module sw_demux_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,       // already synchronised, active-low key level
  output logic level,     // debounced level, 1 = released
  output logic fall_evt   // 1-cycle pulse, the cycle after level falls
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          level_d;

  // A level is accepted only after it differs from the debounced level for
  // DEBOUNCE_CYCLES consecutive cycles. Any return to agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= 1'b1;
      level_d  <= 1'b1;
      cnt      <= '0;
      fall_evt <= 1'b0;
    end else begin
      level_d  <= level;
      fall_evt <= level_d & ~level;
      if (din == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TOP) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module sw_demux_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACK_CYCLES      = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [9:0] LEDR
);
  localparam int AW = $clog2(ACK_CYCLES) + 1;
  localparam logic [AW-1:0] ACK_TOP = AW'(ACK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_REL} state_t;

  // Bit 4 is the destination select s, and bits 3:0 are the data D.
  logic [4:0]    sw_s1, sw_s2;
  logic [1:0]    key_s1, key_s2;
  logic [1:0]    key_db, key_evt;
  logic [3:0]    x_reg, y_reg;
  logic          ack;
  logic [AW-1:0] ack_cnt;
  state_t        state;

  // SW[8:4] has no function on this board.
  logic sw_unused;
  assign sw_unused = &{1'b0, SW[8:4]};

  // Two-flop synchronisers. Switches reset low, and the active-low keys reset to released.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
    end else begin
      sw_s1  <= {SW[9], SW[3:0]};
      sw_s2  <= sw_s1;
      key_s1 <= KEY;
      key_s2 <= key_s1;
    end
  end

  // Each key gets its own debouncer. Key 0 is load, and key 1 is clear.
  for (genvar k = 0; k < 2; k++) begin : g_db
    sw_demux_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (CLOCK_50),
      .rst      (RESET),
      .din      (key_s2[k]),
      .level    (key_db[k]),
      .fall_evt (key_evt[k])
    );
  end

  // Write/acknowledge FSM. Load has priority over clear.
  // Events outside IDLE are dropped, and WAIT_REL makes a held key give a single write.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state   <= IDLE;
      x_reg   <= '0;
      y_reg   <= '0;
      ack     <= 1'b0;
      ack_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_evt[0] || key_evt[1]) begin
            if (sw_s2[4]) y_reg <= key_evt[0] ? sw_s2[3:0] : 4'h0;
            else          x_reg <= key_evt[0] ? sw_s2[3:0] : 4'h0;
            state   <= ACK;
            ack     <= 1'b1;
            ack_cnt <= '0;
          end
        end
        ACK: begin
          if (ack_cnt == ACK_TOP) begin
            state <= WAIT_REL;
            ack   <= 1'b0;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (&key_db) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  assign LEDR = {sw_s2[4], ack, y_reg, x_reg};
endmodule
